// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the FSM state types of the SRAM slave.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } axi_burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  localparam logic [1:0] BURST_RSVD = 2'd3;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi_interface.sv
// AXI4 bundle with master and slave modports; widths follow the slave parameters.
interface axi_interface #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  logic [AXI_ID_WIDTH-1:0]     awid;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awlock;
  logic [3:0]                  awcache;
  logic [2:0]                  awprot;
  logic [3:0]                  awqos;
  logic [3:0]                  awregion;
  logic [AXI_USER_WIDTH-1:0]   awuser;
  logic                        awvalid;
  logic                        awready;

  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wlast;
  logic [AXI_USER_WIDTH-1:0]   wuser;
  logic                        wvalid;
  logic                        wready;

  logic [AXI_ID_WIDTH-1:0]     bid;
  logic [1:0]                  bresp;
  logic [AXI_USER_WIDTH-1:0]   buser;
  logic                        bvalid;
  logic                        bready;

  logic [AXI_ID_WIDTH-1:0]     arid;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arlock;
  logic [3:0]                  arcache;
  logic [2:0]                  arprot;
  logic [3:0]                  arqos;
  logic [3:0]                  arregion;
  logic [AXI_USER_WIDTH-1:0]   aruser;
  logic                        arvalid;
  logic                        arready;

  logic [AXI_ID_WIDTH-1:0]     rid;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic [AXI_USER_WIDTH-1:0]   ruser;
  logic                        rvalid;
  logic                        rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid, rready,
    input  awready, wready, bid, bresp, buser, bvalid, arready,
           rid, rdata, rresp, rlast, ruser, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid, rready,
    output awready, wready, bid, bresp, buser, bvalid, arready,
           rid, rdata, rresp, rlast, ruser, rvalid
  );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address, last-beat flag and request legality for one AXI direction.
// WRAP support is built only when AXI_SRAM_WRAP_EN is defined.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_SIZE   = 2
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  input  logic [7:0]            beat_cnt_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o,
  output logic                  last_o,
  output logic                  req_err_o
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_addr;
  logic                  wrap_ok;

  assign step      = ADDR_WIDTH'(1) << size_i;
  assign incr_addr = (addr_i & ~(step - ADDR_WIDTH'(1))) + step;

`ifdef AXI_SRAM_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;

  // Container is (len+1)*2^size bytes; legal lengths make it a power of two.
  assign wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
  assign wrap_addr = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
  assign wrap_ok   = len_i inside {8'd1, 8'd3, 8'd7, 8'd15};
`else
  assign wrap_addr = addr_i;
  assign wrap_ok   = 1'b0;
`endif

  assign last_o = (beat_cnt_i == len_i);

  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      INCR:    next_addr_o = incr_addr;
      WRAP:    next_addr_o = wrap_addr;
      default: next_addr_o = addr_i;
    endcase
  end

  assign req_err_o = (32'(size_i) > MAX_SIZE) ||
                     (burst_i == BURST_RSVD) ||
                     ((burst_i == WRAP) && !wrap_ok);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave on a word-addressed SRAM; independent write and read FSMs, one
// transaction outstanding per direction. WRAP bursts need AXI_SRAM_WRAP_EN.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned MEM_DEPTH      = 1024
) (
  input logic         clk,
  input logic         rst,
  axi_interface.slave axi
);

  localparam int unsigned OFS    = $clog2(AXI_DATA_WIDTH / 8);
  localparam int unsigned IDXW   = $clog2(MEM_DEPTH);
  localparam int unsigned NBYTES = AXI_DATA_WIDTH / 8;

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  function automatic logic out_of_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >> (OFS + IDXW)) != '0;
  endfunction

  // ---------------- write path ----------------
  w_state_e                  w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0]   aw_id_q, aw_id_d;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]                aw_len_q, aw_len_d;
  logic [2:0]                aw_size_q, aw_size_d;
  logic [1:0]                aw_burst_q, aw_burst_d;
  logic [AXI_USER_WIDTH-1:0] aw_user_q, aw_user_d;
  logic [7:0]                w_cnt_q, w_cnt_d;
  logic                      w_err_q, w_err_d;

  logic [AXI_ADDR_WIDTH-1:0] w_next_addr;
  logic                      w_last, w_req_err, w_beat_err;
  logic                      aw_ready, w_ready, b_valid, mem_we;
  logic [IDXW-1:0]           w_idx;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (AXI_ADDR_WIDTH),
    .MAX_SIZE   (OFS)
  ) u_wr_addr (
    .addr_i      (aw_addr_q),
    .len_i       (aw_len_q),
    .size_i      (aw_size_q),
    .burst_i     (aw_burst_q),
    .beat_cnt_i  (w_cnt_q),
    .next_addr_o (w_next_addr),
    .last_o      (w_last),
    .req_err_o   (w_req_err)
  );

  assign w_idx      = aw_addr_q[OFS +: IDXW];
  assign w_beat_err = w_req_err || out_of_range(aw_addr_q) || (axi.wlast != w_last);

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    aw_user_d  = aw_user_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    b_valid    = 1'b0;
    mem_we     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready = ~rst;
        if (aw_ready && axi.awvalid) begin
          aw_id_d    = axi.awid;
          aw_addr_d  = axi.awaddr;
          aw_len_d   = axi.awlen;
          aw_size_d  = axi.awsize;
          aw_burst_d = axi.awburst;
          aw_user_d  = axi.awuser;
          w_cnt_d    = '0;
          w_err_d    = 1'b0;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (axi.wvalid) begin
          // An erring beat is itself suppressed and poisons the rest of the burst.
          mem_we    = ~rst && !w_err_q && !w_beat_err;
          w_err_d   = w_err_q || w_beat_err;
          aw_addr_d = w_next_addr;
          w_cnt_d   = w_cnt_q + 8'd1;
          if (w_last) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_user_q  <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      aw_user_q  <= aw_user_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (axi.wstrb[b]) mem_q[w_idx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e                  r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]                ar_len_q, ar_len_d;
  logic [2:0]                ar_size_q, ar_size_d;
  logic [1:0]                ar_burst_q, ar_burst_d;
  logic [AXI_USER_WIDTH-1:0] ar_user_q, ar_user_d;
  logic [7:0]                r_cnt_q, r_cnt_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  axi_resp_e                 rresp_q;

  logic [AXI_ADDR_WIDTH-1:0] r_next_addr;
  logic                      r_last, r_req_err, r_fetch_err;
  logic                      ar_ready, r_valid;
  logic [IDXW-1:0]           r_idx;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (AXI_ADDR_WIDTH),
    .MAX_SIZE   (OFS)
  ) u_rd_addr (
    .addr_i      (ar_addr_q),
    .len_i       (ar_len_q),
    .size_i      (ar_size_q),
    .burst_i     (ar_burst_q),
    .beat_cnt_i  (r_cnt_q),
    .next_addr_o (r_next_addr),
    .last_o      (r_last),
    .req_err_o   (r_req_err)
  );

  assign r_idx       = ar_addr_q[OFS +: IDXW];
  assign r_fetch_err = r_req_err || out_of_range(ar_addr_q);

  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    ar_user_d  = ar_user_q;
    r_cnt_d    = r_cnt_q;
    ar_ready   = 1'b0;
    r_valid    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready = ~rst;
        if (ar_ready && axi.arvalid) begin
          ar_id_d    = axi.arid;
          ar_addr_d  = axi.araddr;
          ar_len_d   = axi.arlen;
          ar_size_d  = axi.arsize;
          ar_burst_d = axi.arburst;
          ar_user_d  = axi.aruser;
          r_cnt_d    = '0;
          r_state_d  = R_FETCH;
        end
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: begin
        r_valid = 1'b1;
        if (axi.rready) begin
          if (r_last) begin
            r_state_d = R_IDLE;
          end else begin
            ar_addr_d = r_next_addr;
            r_cnt_d   = r_cnt_q + 8'd1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_user_q  <= '0;
      r_cnt_q    <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      ar_user_q  <= ar_user_d;
      r_cnt_q    <= r_cnt_d;
    end
  end

  // Non-blocking read of mem_q: a same-cycle write to this word returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (r_state_q == R_FETCH) begin
      rdata_q <= r_fetch_err ? '0 : mem_q[r_idx];
      rresp_q <= r_fetch_err ? SLVERR : OKAY;
    end
  end

  // ---------------- outputs ----------------
  assign axi.awready = aw_ready;
  assign axi.wready  = w_ready;
  assign axi.bvalid  = b_valid;
  assign axi.bid     = aw_id_q;
  assign axi.bresp   = w_err_q ? SLVERR : OKAY;
  assign axi.buser   = aw_user_q;

  assign axi.arready = ar_ready;
  assign axi.rvalid  = r_valid;
  assign axi.rlast   = r_valid && r_last;
  assign axi.rid     = ar_id_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign axi.ruser   = ar_user_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave; expectations follow AXI_SRAM_WRAP_EN if defined.
module tb_axi_sram_slave;

  localparam int unsigned AW = 32, DW = 32, IW = 4, UW = 1, DEPTH = 1024;
  localparam logic [31:0] MEM_BYTES = 32'h1000;
`ifdef AXI_SRAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_interface #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                  .AXI_USER_WIDTH(UW)) axi_if ();

  axi_sram_slave #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                   .AXI_USER_WIDTH(UW), .MEM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .axi (axi_if)
  );

  typedef struct packed { logic [31:0] data; logic [1:0] resp; logic last; } rexp_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } bexp_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] mdl [1024];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          vecs = 0;
  int          miscmp = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit req_bad(input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
    bit wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'd2) || (burst == 2'd3) || (burst == 2'd2 && !(WRAP_EN && wrap_len_ok));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int i);
    logic [31:0] step, algn, cont, base;
    step = 32'd1 << size;
    algn = (start / step) * step;
    if (i == 0 || burst == 2'd0) return start;
    if (burst == 2'd2) begin
      cont = (32'(len) + 32'd1) * step;
      base = (start / cont) * cont;
      return base + (((algn - base) + 32'(i) * step) % cont);
    end
    return algn + 32'(i) * step;
  endfunction

  task automatic axi_wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst,
                        input int bad_beat, input int bp);
    logic        err, bad;
    logic [31:0] a;
    bexp_t       be;
    int          n;
    err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a   = beat_addr(addr, len, size, burst, i);
      bad = req_bad(len, size, burst) || (a >= MEM_BYTES) || (i == bad_beat);
      if (!err && !bad)
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mdl[a[11:2]][b*8 +: 8] = wd[i][b*8 +: 8];
      err = err | bad;
    end
    bq.push_back('{id: id, resp: err ? 2'd2 : 2'd0});

    @(negedge clk);
    axi_if.awid = id; axi_if.awaddr = addr; axi_if.awlen = len;
    axi_if.awsize = size; axi_if.awburst = burst; axi_if.awuser = id[0];
    axi_if.awvalid = 1'b1;
    n = 0;
    while (!axi_if.awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin chk("aw_timeout", 0, 1); axi_if.awvalid = 1'b0; return; end
    @(negedge clk);
    axi_if.awvalid = 1'b0;
    chk("w_ready_after_aw", axi_if.wready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      axi_if.wdata = wd[i]; axi_if.wstrb = ws[i];
      axi_if.wlast = (i == int'(len)) ^ (i == bad_beat);
      axi_if.wvalid = 1'b1;
      n = 0;
      while (!axi_if.wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin chk("w_timeout", 0, 1); axi_if.wvalid = 1'b0; return; end
      @(negedge clk);
    end
    axi_if.wvalid = 1'b0;
    chk("b_latency", axi_if.bvalid, 1);
    be = bq[0];
    for (int k = 0; k < bp; k++) begin
      chk("b_hold", {axi_if.bvalid, axi_if.bid, axi_if.bresp}, {1'b1, be.id, be.resp});
      @(negedge clk);
    end
    axi_if.bready = 1'b1;
    n = 0;
    while (!axi_if.bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin chk("b_timeout", 0, 1); axi_if.bready = 1'b0; return; end
    be = bq.pop_front();
    chk("bid", axi_if.bid, be.id);
    chk("bresp", axi_if.bresp, be.resp);
    chk("buser", axi_if.buser, be.id[0]);
    @(negedge clk);
    axi_if.bready = 1'b0;
    chk("b_drop", axi_if.bvalid, 0);
  endtask

  task automatic axi_rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    logic        bad;
    rexp_t       e;
    int          n, got, gap;
    for (int i = 0; i <= int'(len); i++) begin
      a   = beat_addr(addr, len, size, burst, i);
      bad = req_bad(len, size, burst) || (a >= MEM_BYTES);
      rq.push_back('{data: bad ? 32'h0 : mdl[a[11:2]], resp: bad ? 2'd2 : 2'd0,
                     last: (i == int'(len))});
    end

    @(negedge clk);
    axi_if.arid = id; axi_if.araddr = addr; axi_if.arlen = len;
    axi_if.arsize = size; axi_if.arburst = burst; axi_if.aruser = id[0];
    axi_if.arvalid = 1'b1;
    n = 0;
    while (!axi_if.arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin chk("ar_timeout", 0, 1); axi_if.arvalid = 1'b0; return; end
    @(negedge clk);
    axi_if.arvalid = 1'b0;
    axi_if.rready  = 1'b1;
    got = 0; gap = 1; n = 0;
    while (got <= int'(len) && n < 200) begin
      if (axi_if.rvalid) begin
        e = rq.pop_front();
        chk("r_gap", gap, 2);
        chk("rdata", axi_if.rdata, e.data);
        chk("rresp", axi_if.rresp, e.resp);
        chk("rlast", axi_if.rlast, e.last);
        chk("rid", {axi_if.rid, axi_if.ruser}, {id, id[0]});
        got++;
        gap = 0;
      end
      @(negedge clk);
      gap++; n++;
    end
    if (got <= int'(len)) chk("r_timeout", got, int'(len) + 1);
    axi_if.rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [3:0]  rid;
    for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
    rst = 1'b1;
    axi_if.awvalid = 0; axi_if.wvalid = 0; axi_if.bready = 0;
    axi_if.arvalid = 0; axi_if.rready = 0;
    axi_if.awid = 0; axi_if.awaddr = 0; axi_if.awlen = 0; axi_if.awsize = 0;
    axi_if.awburst = 0; axi_if.awlock = 0; axi_if.awcache = 0; axi_if.awprot = 0;
    axi_if.awqos = 0; axi_if.awregion = 0; axi_if.awuser = 0;
    axi_if.wdata = 0; axi_if.wstrb = 0; axi_if.wlast = 0; axi_if.wuser = 0;
    axi_if.arid = 0; axi_if.araddr = 0; axi_if.arlen = 0; axi_if.arsize = 0;
    axi_if.arburst = 0; axi_if.arlock = 0; axi_if.arcache = 0; axi_if.arprot = 0;
    axi_if.arqos = 0; axi_if.arregion = 0; axi_if.aruser = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {axi_if.awready, axi_if.wready, axi_if.arready}, 0);
    chk("rst_valid", {axi_if.bvalid, axi_if.rvalid, axi_if.rlast}, 0);
    chk("rst_b", {axi_if.bid, axi_if.bresp, axi_if.buser}, 0);
    chk("rst_r", {axi_if.rid, axi_if.rdata, axi_if.rresp, axi_if.ruser}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", {axi_if.awready, axi_if.arready}, 2'b11);

    // INCR burst write/read
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
    axi_wr(4'd5, 32'h10, 8'd3, 3'd2, 2'd1, -1, 0);
    axi_rd(4'd6, 32'h10, 8'd3, 3'd2, 2'd1);

    // byte strobes
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    axi_wr(4'd1, 32'h0, 8'd0, 3'd2, 2'd1, -1, 0);
    wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
    axi_wr(4'd2, 32'h0, 8'd0, 3'd2, 2'd1, -1, 0);
    axi_rd(4'd2, 32'h0, 8'd0, 3'd2, 2'd1);

    // WRAP over a pre-filled container
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + i; ws[i] = 4'hF; end
    axi_wr(4'd3, 32'h30, 8'd3, 3'd2, 2'd1, -1, 0);
    for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + i;
    axi_wr(4'd4, 32'h38, 8'd3, 3'd2, 2'd2, -1, 0);
    axi_rd(4'd4, 32'h30, 8'd3, 3'd2, 2'd1);
    axi_rd(4'd7, 32'h38, 8'd3, 3'd2, 2'd2);
    axi_rd(4'd7, 32'h30, 8'd2, 3'd2, 2'd2);

    // out of range: write must not alias onto word 0
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    axi_wr(4'd8, 32'h1000, 8'd0, 3'd2, 2'd1, -1, 0);
    axi_rd(4'd8, 32'h0, 8'd0, 3'd2, 2'd1);
    axi_rd(4'd9, 32'h1000, 8'd1, 3'd2, 2'd1);
    axi_rd(4'd9, 32'hFFC, 8'd1, 3'd2, 2'd1);

    // wlast disagreeing with the beat count
    for (int i = 0; i < 2; i++) begin wd[i] = 32'h5050_0000 + i; ws[i] = 4'hF; end
    axi_wr(4'd10, 32'h40, 8'd1, 3'd2, 2'd1, -1, 0);
    for (int i = 0; i < 2; i++) wd[i] = 32'h6060_0000 + i;
    axi_wr(4'd11, 32'h40, 8'd1, 3'd2, 2'd1, 0, 0);
    axi_rd(4'd11, 32'h40, 8'd1, 3'd2, 2'd1);

    // illegal size / reserved burst
    axi_rd(4'd12, 32'h10, 8'd0, 3'd3, 2'd1);
    axi_rd(4'd12, 32'h10, 8'd1, 3'd2, 2'd3);

    // FIXED burst: every beat hits the same word
    for (int i = 0; i < 3; i++) begin wd[i] = 32'hD0 + i; ws[i] = 4'hF; end
    axi_wr(4'd13, 32'h60, 8'd2, 3'd2, 2'd0, -1, 0);
    axi_rd(4'd13, 32'h60, 8'd1, 3'd2, 2'd0);

    // B backpressure with a concurrent read
    for (int i = 0; i < 2; i++) begin wd[i] = 32'hE0 + i; ws[i] = 4'hF; end
    fork
      axi_wr(4'd9, 32'h70, 8'd1, 3'd2, 2'd1, -1, 5);
      axi_rd(4'd3, 32'h10, 8'd3, 3'd2, 2'd1);
    join
    axi_rd(4'd14, 32'h70, 8'd1, 3'd2, 2'd1);

    // random INCR write then read-back
    for (int t = 0; t < 10; t++) begin
      ra  = 32'($urandom_range(0, 1000)) * 32'd4;
      rl  = 8'($urandom_range(0, 7));
      rid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      axi_wr(rid, ra, rl, 3'd2, 2'd1, -1, 0);
      axi_rd(rid, ra, rl, 3'd2, 2'd1);
    end

    if (rq.size() != 0 || bq.size() != 0) chk("queues_empty", rq.size() + bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 slave endpoint backed by an on-chip word-addressed SRAM array. It sits directly downstream of an `axi_interface` instance bound through its `slave` modport and terminates every burst the master issues. It also serves as the default memory target for controller bring-up and verification. The write and read paths are independent, with at most one outstanding transaction per direction.

## Interface
- `AXI_ADDR_WIDTH`, default 32: address width.
- `AXI_DATA_WIDTH`, default 32: data width; must be 32 or 64.
- `AXI_ID_WIDTH`, default 4: ID width.
- `AXI_USER_WIDTH`, default 1: user-signal width.
- `MEM_DEPTH`, default 1024: number of data words; must be a power of two.

Ports:
- `clk`  input  1  single clock; all logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `axi`  interface  `axi_interface.slave`  complete AXI4 slave port; widths come from the parameters above.

## Operation
- Byte offset bits: `OFS = log2(AXI_DATA_WIDTH/8)`. Word index: `addr[OFS +: log2(MEM_DEPTH)]`.
- Out of range: any beat address at or above `MEM_DEPTH*AXI_DATA_WIDTH/8`.
- Write FSM:
  - `W_IDLE`: `awready`=1. On AW handshake, capture id, addr, len, size, burst and user, clear the error flag, then go to `W_DATA`.
  - `W_DATA`: `wready`=1. On each W handshake:
    - write the bytes enabled by `wstrb` unless the error flag is set or the beat is out of range;
    - advance the address and increment the beat counter.
  - `W_DATA` exit: on beat number len+1, go to `W_RESP`. The beat count is authoritative; `wlast` does not end the burst.
  - `W_RESP`: `bvalid`=1, with `bid`/`buser` set to the captured values. Hold until `bready`, then go to `W_IDLE`.
- Read FSM:
  - `R_IDLE`: `arready`=1. On AR handshake, capture the request and go to `R_FETCH`.
  - `R_FETCH`: one cycle. Register the memory word into `rdata`. Load 0 if the beat is out of range or the error flag is set. Go to `R_DATA`.
  - `R_DATA`: `rvalid`=1; `rlast`=1 on beat len+1. On `rready`: if the beat was last, go to `R_IDLE`, otherwise advance the address and go to `R_FETCH`.
- Error (SLVERR) conditions. Any of these makes the response SLVERR and suppresses memory writes:
  - size greater than `OFS`;
  - burst==3;
  - WRAP with len not in {1,3,7,15};
  - a `wlast` value that disagrees with the beat count on any beat;
  - any out-of-range beat.
- Response values: `bresp` is SLVERR if any beat erred, otherwise OKAY. `rresp` is evaluated per beat. EXOKAY and DECERR are never issued.
- Address update:
  - FIXED: the address is unchanged.
  - INCR: next = (addr aligned down to 2^size) + 2^size.
  - WRAP: the same increment, wrapped within a container of (len+1)·2^size bytes aligned to that container size.
- Narrow transfers: writes rely on `wstrb` only. Reads always return the full word.
- The 4 KB boundary is not checked. Lock, cache, prot, qos and region are ignored.
- Read/write collision: a fetch and a write to the same word in the same cycle return the old data.

## Timing
- Reset (`rst`=1): `awready`, `wready`, `bvalid`, `arready`, `rvalid`, `rlast` are 0. `bid`, `bresp`, `buser`, `rid`, `rdata`, `rresp`, `ruser` are 0. Both FSMs are in IDLE. Memory contents are not reset.
- `awready`/`arready` read 1 in the first cycle after `rst` falls.
- Write timing: AW handshake in cycle N gives `wready`=1 from N+1. A W handshake on the last beat in cycle M gives `bvalid`=1 at M+1.
- Read timing: AR handshake in cycle N gives `rvalid`=1 at N+2. Each following beat appears 2 cycles after the previous R handshake, so read throughput is 1 beat per 2 cycles.
- Write throughput is 1 beat per cycle.
- `bvalid`/`rvalid` and their payloads stay stable until the handshake.
- Reset mid-burst: the transaction is abandoned and no B or R response is issued. Words already written persist.
- The read and write FSMs run concurrently and do not stall each other.

## Configuration
- `AXI_SRAM_WRAP_EN` defined: WRAP bursts are supported as described in Operation.
- `AXI_SRAM_WRAP_EN` undefined:
  - every WRAP burst is an error;
  - writes complete the full W data phase with no memory update, then respond SLVERR;
  - reads return len+1 beats of 0 with SLVERR;
  - the WRAP logic is not synthesized.

## Structure
- `axi_pkg` contains:
  - `axi_burst_e` (FIXED=0, INCR=1, WRAP=2);
  - `axi_resp_e` (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3);
  - the FSM state enums.
- Sub-module `axi_burst_addr_gen` (combinational next-address and request-legality check) is instantiated once per direction.
- The memory array, both FSMs and the counters live in `axi_sram_slave`.

## Test plan
- Reset: hold `rst` for 3 cycles → all outputs 0. Release → `awready`=`arready`=1 on the next cycle.
- INCR write: len=3, size=2, addr 0x10, data 0xA0..0xA3, strb 0xF, awid 5 → `bresp`=OKAY, `bid`=5. Read back the same burst → 0xA0..0xA3, `rlast` on beat 4 only, OKAY.
- Strobes: write 0xFFFFFFFF to 0x0, then 0x11223344 with strb 0b0101 → read returns 0xFF22FF44.
- WRAP: len=3, size=2, addr 0x38 → beats at 0x38, 0x3C, 0x30, 0x34. Without the macro → SLVERR and memory unchanged.
- Out of range: write to 0x1000 with `MEM_DEPTH`=1024 → SLVERR and no write. Read there with len=1 → two beats of 0 with SLVERR, `rlast` on the second.
- Backpressure: hold `bready` low 5 cycles → `bvalid`, `bid`, `bresp` held stable, while a concurrent read completes unaffected.
